pll_phase_divider: RTL and testbench



---
 rtl/pll_phase_pkg.sv | 42 ++++
 rtl/pll_phase_divider_tap_delay.sv | 59 +++++
 rtl/pll_phase_divider.sv | 118 +++++++++++
 tb/tb_pll_phase_divider.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_pkg.sv
// -----------------------------------------------------------------------------
// pll_phase_pkg
// Shared definitions for the PLL output-stage divider helpers:
//   - divide-mode encodings for the shift-register divider
//   - history depth / tap width of the phase delay line
//   - div_len()   : divide length N for a mode
//   - phase_lag() : 90-degree lag D (in cycles) for a mode
// -----------------------------------------------------------------------------
package pll_phase_pkg;

    // Divide-mode encodings. 2'b10 is not a legal mode.
    localparam logic [1:0] DIV4        = 2'b00;
    localparam logic [1:0] DIV7        = 2'b01;
    localparam logic [1:0] DIV5        = 2'b11;
    localparam logic [1:0] DIV_ILLEGAL = 2'b10;

    // Largest selectable delay and the resulting history depth / tap width.
    localparam int unsigned MAX_DLY    = 15;
    localparam int unsigned HIST_DEPTH = MAX_DLY + 1;
    localparam int unsigned DLY_W      = 4;

    // Phase counter width; large enough for the longest ratio (7).
    localparam int unsigned CNT_W      = 3;

    // Divide length N. The illegal mode falls back to divide-by-4.
    function automatic int unsigned div_len(input logic [1:0] mode);
        int unsigned n;
        case (mode)
            DIV7:    n = 7;
            DIV5:    n = 5;
            default: n = 4;
        endcase
        return n;
    endfunction

    // Quarter-period lag: N/4 rounded to the nearest cycle with ties going
    // down, which is floor((N+1)/4). Gives 1 for N=4, 1 for N=5, 2 for N=7.
    function automatic int unsigned phase_lag(input logic [1:0] mode);
        return (div_len(mode) + 1) / 4;
    endfunction

endpackage

// File: rtl/pll_phase_divider_tap_delay.sv
// -----------------------------------------------------------------------------
// tap_delay
// Tap-selectable delay line for a single-bit level.
//
// The history is DEPTH entries long: entry 0 is the value being loaded on
// this edge (d_i), entry i is the value loaded i edges earlier. On every
// rising edge the output register captures entry tap_i, so q_o equals the
// d_i stream delayed by tap_i cycles, and tap_i = 0 makes q_o track d_i
// edge for edge. A tap change takes effect at the next rising edge with no
// glitch suppression.
//
// Ports:
//   clk    - clock, rising edge
//   srst   - synchronous active-high reset; clears history and output
//   d_i    - next-state value of the level being delayed
//   tap_i  - delay in cycles (0 .. DEPTH-1)
//   q_o    - delayed level (registered)
// -----------------------------------------------------------------------------
module tap_delay
    import pll_phase_pkg::*;
#(
    parameter int unsigned DEPTH = HIST_DEPTH,
    parameter int unsigned TAP_W = DLY_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             d_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic             q_o
);

    // Entry 0 is the incoming value itself, so only DEPTH-1 entries need
    // storage.
    logic [DEPTH-1:0] hist_d;
    logic [DEPTH-2:0] hist_q;
    logic             q_q;

    assign hist_d[0] = d_i;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_hist
            assign hist_d[gi] = hist_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            hist_q <= '0;
            q_q    <= 1'b0;
        end else begin
            hist_q <= hist_d[DEPTH-2:0];
            q_q    <= hist_d[tap_i];
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pll_phase_divider.sv
// -----------------------------------------------------------------------------
// pll_phase_divider
// Synchronous model of the PLL output-stage helpers: a shift-register style
// clock divider (/4, /7, /5) with 0-degree and quantised 90-degree phase
// outputs, a /2 "half" output, and a tap-selectable delay of the 0-degree
// phase. All outputs are registered levels in the clk domain.
//
// Parameters:
//   SHIFTREG_DIV_MODE      - 00: /4, 01: /7, 11: /5, 10: illegal (runs /4)
//   DELAY_ADJUSTMENT_MODE  - "DYNAMIC" uses dly_adj; anything else is fixed
//   FIXED_DELAY_ADJUSTMENT - delay (0..15 cycles) used in fixed mode
//
// Ports:
//   clk        - generated clock, rising edge
//   init       - synchronous active-high reset
//   dly_adj    - dynamic delay in cycles (ignored in fixed mode)
//   phase0     - divided output, 0 degrees, high for floor(N/2) of N cycles
//   phase90    - phase0 lagged by the quarter-period D
//   half       - toggles every cycle
//   phase_dly  - phase0 delayed by the selected number of cycles
//   cfg_err    - static flag, 1 when the divide mode is illegal
// -----------------------------------------------------------------------------
module pll_phase_divider
    import pll_phase_pkg::*;
#(
    parameter logic [1:0]       SHIFTREG_DIV_MODE      = 2'b00,
    parameter string            DELAY_ADJUSTMENT_MODE  = "FIXED",
    parameter logic [DLY_W-1:0] FIXED_DELAY_ADJUSTMENT = 4'b0000
) (
    input  logic             clk,
    input  logic             init,
    input  logic [DLY_W-1:0] dly_adj,
    output logic             phase0,
    output logic             phase90,
    output logic             half,
    output logic             phase_dly,
    output logic             cfg_err
);

    localparam int unsigned      DIV_N       = div_len(SHIFTREG_DIV_MODE);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DIV_N - 1);
    localparam logic [CNT_W-1:0] HIGH_LEN    = CNT_W'(DIV_N / 2);
    localparam logic [DLY_W-1:0] LAG_TAP     = DLY_W'(phase_lag(SHIFTREG_DIV_MODE));
    localparam bit               DLY_DYNAMIC = (DELAY_ADJUSTMENT_MODE == "DYNAMIC");

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             phase0_q;
    logic             phase0_d;
    logic             half_q;
    logic             half_d;
    logic [DLY_W-1:0] dly_tap;

    // -------------------------------------------------------------------------
    // Phase counter, 0-degree output and half-rate toggle
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
        // phase0 is registered from the current count, so the edge that
        // leaves cnt=0 is the first one to drive phase0 high.
        phase0_d = (cnt_q < HIGH_LEN);
        half_d   = ~half_q;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            cnt_q    <= '0;
            phase0_q <= 1'b0;
            half_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase0_q <= phase0_d;
            half_q   <= half_d;
        end
    end

    // -------------------------------------------------------------------------
    // Delayed copies of phase0
    // Both delay lines are fed with phase0's next-state value so that a tap of
    // zero reproduces phase0 exactly and a tap of k lags it by k edges.
    // -------------------------------------------------------------------------
    assign dly_tap = DLY_DYNAMIC ? dly_adj : FIXED_DELAY_ADJUSTMENT;

    tap_delay #(
        .DEPTH (HIST_DEPTH),
        .TAP_W (DLY_W)
    ) u_phase_dly (
        .clk   (clk),
        .srst  (init),
        .d_i   (phase0_d),
        .tap_i (dly_tap),
        .q_o   (phase_dly)
    );

    // The 90-degree output is the same delay line with a constant tap; the
    // unused history beyond the lag is trimmed away by synthesis.
    tap_delay #(
        .DEPTH (HIST_DEPTH),
        .TAP_W (DLY_W)
    ) u_phase90 (
        .clk   (clk),
        .srst  (init),
        .d_i   (phase0_d),
        .tap_i (LAG_TAP),
        .q_o   (phase90)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign phase0  = phase0_q;
    assign half    = half_q;
    assign cfg_err = (SHIFTREG_DIV_MODE == DIV_ILLEGAL);

endmodule

// File: tb/tb_pll_phase_divider.sv
// -----------------------------------------------------------------------------
// tb_pll_phase_divider
// Five divider instances share clk/init/dly_adj:
//   u4 : /4, fixed delay 0
//   u7 : /7, fixed delay 3
//   u5 : /5, fixed delay 0
//   ub : illegal mode 10, fixed delay 0
//   ud : /7, dynamic delay (fixed value 9 must be ignored)
// Each instance's outputs are packed as {cfg_err, phase_dly, half, phase90,
// phase0} and compared against hand-derived sequences once per cycle.
// -----------------------------------------------------------------------------
module tb_pll_phase_divider;

    logic       clk;
    logic       init;
    logic [3:0] dly_adj;

    logic [4:0] o4;
    logic [4:0] o7;
    logic [4:0] o5;
    logic [4:0] ob;
    logic [4:0] od;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pll_phase_divider #(
        .SHIFTREG_DIV_MODE      (2'b00),
        .DELAY_ADJUSTMENT_MODE  ("FIXED"),
        .FIXED_DELAY_ADJUSTMENT (4'd0)
    ) u4 (
        .clk (clk), .init (init), .dly_adj (dly_adj),
        .phase0 (o4[0]), .phase90 (o4[1]), .half (o4[2]),
        .phase_dly (o4[3]), .cfg_err (o4[4])
    );

    pll_phase_divider #(
        .SHIFTREG_DIV_MODE      (2'b01),
        .DELAY_ADJUSTMENT_MODE  ("FIXED"),
        .FIXED_DELAY_ADJUSTMENT (4'd3)
    ) u7 (
        .clk (clk), .init (init), .dly_adj (dly_adj),
        .phase0 (o7[0]), .phase90 (o7[1]), .half (o7[2]),
        .phase_dly (o7[3]), .cfg_err (o7[4])
    );

    pll_phase_divider #(
        .SHIFTREG_DIV_MODE      (2'b11),
        .DELAY_ADJUSTMENT_MODE  ("FIXED"),
        .FIXED_DELAY_ADJUSTMENT (4'd0)
    ) u5 (
        .clk (clk), .init (init), .dly_adj (dly_adj),
        .phase0 (o5[0]), .phase90 (o5[1]), .half (o5[2]),
        .phase_dly (o5[3]), .cfg_err (o5[4])
    );

    pll_phase_divider #(
        .SHIFTREG_DIV_MODE      (2'b10),
        .DELAY_ADJUSTMENT_MODE  ("FIXED"),
        .FIXED_DELAY_ADJUSTMENT (4'd0)
    ) ub (
        .clk (clk), .init (init), .dly_adj (dly_adj),
        .phase0 (ob[0]), .phase90 (ob[1]), .half (ob[2]),
        .phase_dly (ob[3]), .cfg_err (ob[4])
    );

    pll_phase_divider #(
        .SHIFTREG_DIV_MODE      (2'b01),
        .DELAY_ADJUSTMENT_MODE  ("DYNAMIC"),
        .FIXED_DELAY_ADJUSTMENT (4'd9)
    ) ud (
        .clk (clk), .init (init), .dly_adj (dly_adj),
        .phase0 (od[0]), .phase90 (od[1]), .half (od[2]),
        .phase_dly (od[3]), .cfg_err (od[4])
    );

    // Expected phase0 after the e-th rising edge following reset release
    // (e <= 0 means reset/pre-reset history, which reads as 0).
    // Waveforms: /4 1100, /5 11000, /7 1110000.
    function automatic logic exp_p0(input int n, input int e);
        logic [6:0] pat;
        int         idx;
        if (e < 1) return 1'b0;
        case (n)
            7:       pat = 7'b1110000;
            default: pat = 7'b1100000;
        endcase
        idx = (e - 1) % n;
        return pat[6 - idx];
    endfunction

    // Hold init for n rising edges; returns at a falling edge with init low.
    task automatic apply_reset(input int n);
        @(negedge clk);
        init = 1'b1;
        repeat (n) @(negedge clk);
        init = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        init = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (o4 !== 5'b00000) begin
            errors++; $display("FAIL reset_div4 got %b expected %b", o4, 5'b00000);
        end else $display("reset_div4 out=%b", o4);
        checks++;
        if (o7 !== 5'b00000) begin
            errors++; $display("FAIL reset_div7 got %b expected %b", o7, 5'b00000);
        end else $display("reset_div7 out=%b", o7);
        checks++;
        if (o5 !== 5'b00000) begin
            errors++; $display("FAIL reset_div5 got %b expected %b", o5, 5'b00000);
        end else $display("reset_div5 out=%b", o5);
        checks++;
        if (ob !== 5'b10000) begin
            errors++; $display("FAIL reset_illegal got %b expected %b", ob, 5'b10000);
        end else $display("reset_illegal out=%b", ob);
        checks++;
        if (od !== 5'b00000) begin
            errors++; $display("FAIL reset_dyn got %b expected %b", od, 5'b00000);
        end else $display("reset_dyn out=%b", od);
        init = 1'b0;
    endtask

    task automatic test_div4();
        logic [4:0] exp;
        apply_reset(3);
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            exp = {1'b0, exp_p0(4, e), 1'(e % 2), exp_p0(4, e - 1), exp_p0(4, e)};
            checks++;
            if (o4 !== exp) begin
                errors++; $display("FAIL div4 e=%0d got %b expected %b", e, o4, exp);
            end else $display("div4 e=%0d out=%b", e, o4);
        end
    endtask

    task automatic test_div7();
        logic [4:0] exp;
        apply_reset(3);
        for (int e = 1; e <= 23; e++) begin
            @(negedge clk);
            exp = {1'b0, exp_p0(7, e - 3), 1'(e % 2), exp_p0(7, e - 2), exp_p0(7, e)};
            checks++;
            if (o7 !== exp) begin
                errors++; $display("FAIL div7 e=%0d got %b expected %b", e, o7, exp);
            end else $display("div7 e=%0d out=%b", e, o7);
        end
    endtask

    task automatic test_div5();
        logic [4:0] exp;
        apply_reset(2);
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk);
            exp = {1'b0, exp_p0(5, e), 1'(e % 2), exp_p0(5, e - 1), exp_p0(5, e)};
            checks++;
            if (o5 !== exp) begin
                errors++; $display("FAIL div5 e=%0d got %b expected %b", e, o5, exp);
            end else $display("div5 e=%0d out=%b", e, o5);
        end
    endtask

    task automatic test_illegal();
        logic [4:0] exp;
        apply_reset(2);
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            exp = {1'b1, exp_p0(4, e), 1'(e % 2), exp_p0(4, e - 1), exp_p0(4, e)};
            checks++;
            if (ob !== exp) begin
                errors++; $display("FAIL illegal e=%0d got %b expected %b", e, ob, exp);
            end else $display("illegal e=%0d out=%b", e, ob);
        end
    endtask

    // dly_adj is changed at a falling edge and must be used by the very next
    // rising edge: 0 for edges 1..10, 5 for 11..25, 15 for 26..45.
    task automatic test_dynamic();
        logic [4:0] exp;
        int         k;
        dly_adj = 4'd0;
        apply_reset(2);
        for (int e = 1; e <= 45; e++) begin
            if (e == 11) dly_adj = 4'd5;
            if (e == 26) dly_adj = 4'd15;
            k = int'(dly_adj);
            @(negedge clk);
            exp = {1'b0, exp_p0(7, e - k), 1'(e % 2), exp_p0(7, e - 2), exp_p0(7, e)};
            checks++;
            if (od !== exp) begin
                errors++; $display("FAIL dynamic e=%0d k=%0d got %b expected %b", e, k, od, exp);
            end else $display("dynamic e=%0d k=%0d out=%b", e, k, od);
        end
    endtask

    // One-cycle init pulse at cnt=2 of the /7 sequence. The dynamic instance
    // keeps dly_adj=15, so its phase_dly shows whether the history was cleared.
    task automatic test_mid_reset();
        logic [4:0] exp;
        apply_reset(2);
        for (int e = 1; e <= 2; e++) begin
            @(negedge clk);
            exp = {1'b0, exp_p0(7, e - 3), 1'(e % 2), exp_p0(7, e - 2), exp_p0(7, e)};
            checks++;
            if (o7 !== exp) begin
                errors++; $display("FAIL midrst_pre e=%0d got %b expected %b", e, o7, exp);
            end else $display("midrst_pre e=%0d out=%b", e, o7);
        end
        init = 1'b1;
        @(negedge clk);
        checks++;
        if (o7 !== 5'b00000) begin
            errors++; $display("FAIL midrst_zero_div7 got %b expected %b", o7, 5'b00000);
        end else $display("midrst_zero_div7 out=%b", o7);
        checks++;
        if (od !== 5'b00000) begin
            errors++; $display("FAIL midrst_zero_dyn got %b expected %b", od, 5'b00000);
        end else $display("midrst_zero_dyn out=%b", od);
        init = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            exp = {1'b0, exp_p0(7, e - 3), 1'(e % 2), exp_p0(7, e - 2), exp_p0(7, e)};
            checks++;
            if (o7 !== exp) begin
                errors++; $display("FAIL midrst_div7 e=%0d got %b expected %b", e, o7, exp);
            end else $display("midrst_div7 e=%0d out=%b", e, o7);
            exp = {1'b0, exp_p0(7, e - 15), 1'(e % 2), exp_p0(7, e - 2), exp_p0(7, e)};
            checks++;
            if (od !== exp) begin
                errors++; $display("FAIL midrst_dyn e=%0d got %b expected %b", e, od, exp);
            end else $display("midrst_dyn e=%0d out=%b", e, od);
        end
    endtask

    initial begin
        init    = 1'b0;
        dly_adj = 4'd0;
        test_reset();
        test_div4();
        test_div7();
        test_div5();
        test_illegal();
        test_dynamic();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
